// File: rtl/ripple_carry_adder.sv
// ripple_carry_adder: registered unsigned adder built from a chain of one-bit full-adder cells.
//
// Adds two LENGTH-bit unsigned operands with no carry-in.
// Sum and carry-out are registered, so results appear one cycle after the operands.
//
// Ports:
//   clk_i   - clock; all state updates on the rising edge
//   rst_ni  - asynchronous, active-low reset; clears s_o and c_o immediately
//   a_i     - operand A, LENGTH bits, unsigned
//   b_i     - operand B, LENGTH bits, unsigned
//   s_o     - registered sum, (a_i + b_i) mod 2^LENGTH
//   c_o     - registered carry-out of bit LENGTH-1
module ripple_carry_adder #(
  parameter int unsigned LENGTH = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [LENGTH-1:0] a_i,
  input  logic [LENGTH-1:0] b_i,
  output logic [LENGTH-1:0] s_o,
  output logic              c_o
);

  logic [LENGTH-1:0] s_d, s_q;
  logic              c_d, c_q;

  // Each cell keeps its own carry nets and reaches back to the previous cell by name.
  // This keeps the chain free of self-referencing vector bits.
  for (genvar i = 0; i < LENGTH; i++) begin : g_fa
    logic cin;
    logic cout;
    logic prop;

    if (i == 0) begin : g_first
      assign cin = 1'b0;
    end else begin : g_rest
      assign cin = g_fa[i-1].cout;
    end

    assign prop   = a_i[i] ^ b_i[i];
    assign s_d[i] = prop ^ cin;
    assign cout   = (a_i[i] & b_i[i]) | (cin & prop);
  end

  assign c_d = g_fa[LENGTH-1].cout;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s_q <= '0;
      c_q <= 1'b0;
    end else begin
      s_q <= s_d;
      c_q <= c_d;
    end
  end

  assign s_o = s_q;
  assign c_o = c_q;

endmodule

// File: tb/tb_ripple_carry_adder.sv
// tb_ripple_carry_adder: directed self-checking bench for ripple_carry_adder.
//
// Instantiates a 16-bit adder and a 1-bit adder.
// Both instances share the same clock and reset.
module tb_ripple_carry_adder;

  logic        clk;
  logic        rst_n;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] s;
  logic        c;
  logic        a1;
  logic        b1;
  logic        s1;
  logic        c1;

  int checks;
  int failures;

  ripple_carry_adder #(.LENGTH(16)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .a_i    (a),
    .b_i    (b),
    .s_o    (s),
    .c_o    (c)
  );

  ripple_carry_adder #(.LENGTH(1)) dut1 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .a_i    (a1),
    .b_i    (b1),
    .s_o    (s1),
    .c_o    (c1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a     = 16'hffff;
    b     = 16'hffff;
    a1    = 1'b1;
    b1    = 1'b1;
    #2;
    checks++;
    if ({c, s} !== 17'h0_0000) begin
      failures++;
      $display("FAIL reset_async got c=%b s=%h want c=0 s=0000", c, s);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({c, s} !== 17'h0_0000) begin
        failures++;
        $display("FAIL reset_hold[%0d] got c=%b s=%h want c=0 s=0000", i, c, s);
      end
      checks++;
      if ({c1, s1} !== 2'b00) begin
        failures++;
        $display("FAIL reset_hold_len1[%0d] got c=%b s=%b want c=0 s=0", i, c1, s1);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if ({c, s} !== 17'h1_fffe) begin
      failures++;
      $display("FAIL reset_release got c=%b s=%h want c=1 s=fffe", c, s);
    end
  endtask

  task automatic test_plain_add();
    @(negedge clk);
    a = 16'h0010;
    b = 16'h1011;
    step();
    checks++;
    if ({c, s} !== 17'h0_1021) begin
      failures++;
      $display("FAIL plain_add got c=%b s=%h want c=0 s=1021", c, s);
    end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    a = 16'hffff;
    b = 16'h0001;
    step();
    checks++;
    if ({c, s} !== 17'h1_0000) begin
      failures++;
      $display("FAIL wrap got c=%b s=%h want c=1 s=0000", c, s);
    end
    // Carry starting from the top bit only.
    @(negedge clk);
    a = 16'h8000;
    b = 16'h8000;
    step();
    checks++;
    if ({c, s} !== 17'h1_0000) begin
      failures++;
      $display("FAIL top_carry got c=%b s=%h want c=1 s=0000", c, s);
    end
  endtask

  task automatic test_max();
    @(negedge clk);
    a = 16'hffff;
    b = 16'hffff;
    step();
    checks++;
    if ({c, s} !== 17'h1_fffe) begin
      failures++;
      $display("FAIL max got c=%b s=%h want c=1 s=fffe", c, s);
    end
    // Alternating bit pattern: no carries generated anywhere.
    @(negedge clk);
    a = 16'haaaa;
    b = 16'h5555;
    step();
    checks++;
    if ({c, s} !== 17'h0_ffff) begin
      failures++;
      $display("FAIL alt_bits got c=%b s=%h want c=0 s=ffff", c, s);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] va [3];
    logic [15:0] vb [3];
    logic [16:0] exp [3];
    va[0] = 16'h0010; vb[0] = 16'h1011; exp[0] = 17'h0_1021;
    va[1] = 16'hffff; vb[1] = 16'h0001; exp[1] = 17'h1_0000;
    va[2] = 16'h0000; vb[2] = 16'h0000; exp[2] = 17'h0_0000;
    @(negedge clk);
    a = va[0];
    b = vb[0];
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({c, s} !== exp[i]) begin
        failures++;
        $display("FAIL b2b[%0d] got %h want %h", i, {c, s}, exp[i]);
      end
      // Operand glitch between edges must not disturb the outputs.
      a = 16'h1234;
      b = 16'hfedc;
      #2;
      checks++;
      if ({c, s} !== exp[i]) begin
        failures++;
        $display("FAIL b2b_hold[%0d] got %h want %h", i, {c, s}, exp[i]);
      end
      if (i < 2) begin
        a = va[i+1];
        b = vb[i+1];
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    a = 16'h0010;
    b = 16'h1011;
    step();
    checks++;
    if ({c, s} !== 17'h0_1021) begin
      failures++;
      $display("FAIL pre_async got c=%b s=%h want c=0 s=1021", c, s);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({c, s} !== 17'h0_0000) begin
      failures++;
      $display("FAIL async_mid got c=%b s=%h want c=0 s=0000", c, s);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if ({c, s} !== 17'h0_1021) begin
      failures++;
      $display("FAIL async_recover got c=%b s=%h want c=0 s=1021", c, s);
    end
  endtask

  task automatic test_length1();
    @(negedge clk);
    a1 = 1'b1;
    b1 = 1'b1;
    step();
    checks++;
    if ({c1, s1} !== 2'b10) begin
      failures++;
      $display("FAIL len1_max got c=%b s=%b want c=1 s=0", c1, s1);
    end
    @(negedge clk);
    a1 = 1'b1;
    b1 = 1'b0;
    step();
    checks++;
    if ({c1, s1} !== 2'b01) begin
      failures++;
      $display("FAIL len1_one got c=%b s=%b want c=0 s=1", c1, s1);
    end
    @(negedge clk);
    a1 = 1'b0;
    b1 = 1'b0;
    step();
    checks++;
    if ({c1, s1} !== 2'b00) begin
      failures++;
      $display("FAIL len1_zero got c=%b s=%b want c=0 s=0", c1, s1);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    a        = '0;
    b        = '0;
    a1       = 1'b0;
    b1       = 1'b0;
    test_reset();
    test_plain_add();
    test_wrap();
    test_max();
    test_back_to_back();
    test_async_reset();
    test_length1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ripple_carry_adder.md
# ripple_carry_adder

Parameterised unsigned adder built as a ripple chain of one-bit full-adder cells. It adds two `LENGTH`-bit operands with no carry-in, and produces a `LENGTH`-bit sum plus a carry-out. Sum and carry-out are registered, so the block is a drop-in one-cycle arithmetic stage for datapaths that need a simple, area-minimal adder.

## Interface
- `LENGTH`, default 16: operand and sum width in bits. Legal range is 1 or more.
- `clk_i`  input  1  clock; all state updates on the rising edge.
- `rst_ni`  input  1  reset, asynchronous and active-low.
- `a_i`  input  LENGTH  operand A, unsigned.
- `b_i`  input  LENGTH  operand B, unsigned.
- `s_o`  output  LENGTH  registered sum, `(a_i + b_i) mod 2^LENGTH`.
- `c_o`  output  1  registered carry-out of bit `LENGTH-1`.

One clock; reset is asynchronous and active-low.

## Operation
- Datapath: `LENGTH` instances of a full-adder cell, chained through `generate`.
  - Cell i inputs: `a_i[i]`, `b_i[i]`, `carry[i]`.
  - Cell i outputs: `sum[i]`, `carry[i+1]`.
  - Cell equations: `sum = a ^ b ^ cin`; `cout = (a & b) | (cin & (a ^ b))`.
- Carry-in of bit 0 is tied to 0. The block has no carry-in port.
- Carry-out is `carry[LENGTH]`.
- Arithmetic:
  - Unsigned and modular; overflow appears only on `c_o`.
  - `{c_o, s_o}` equals the full `LENGTH+1`-bit sum of `a_i` and `b_i`.
- No signed interpretation, no saturation, no flags other than `c_o`.
- No lookahead or prefix logic. Ripple topology is required.
- `LENGTH == 1` degenerates to a single full adder with cin = 0. It must elaborate and behave correctly.

## Timing
- Inputs are sampled on every rising edge of `clk_i`. There is no enable and no handshake.
- Latency: 1 cycle.
  - Operands present before edge N appear on `s_o`/`c_o` after edge N.
  - Outputs hold until the next edge.
- Throughput: one addition per cycle.
- Reset:
  - While `rst_ni` is low, `s_o = 0` and `c_o = 0`, immediately and regardless of the clock.
  - This holds even if reset asserts mid-operation, between edges.
- Reset release: the first rising edge with `rst_ni` high captures the current `a_i + b_i`.
- Input changes between edges have no effect on the outputs until the next edge.
- Critical path: `a_i[0]`/`b_i[0]` through all `LENGTH` carry stages to the `c_o` register. No internal pipelining.

## Test plan
- Reset: hold `rst_ni=0` with `a_i=16'hffff`, `b_i=16'hffff` and clock running -> `s_o=16'h0000`, `c_o=0` throughout. Release -> next edge gives `s_o=16'hfffe`, `c_o=1`.
- Plain add: `a_i=16'h0010`, `b_i=16'h1011` -> after one edge `s_o=16'h1021`, `c_o=0`.
- Full ripple / wrap: `a_i=16'hffff`, `b_i=16'h0001` -> `s_o=16'h0000`, `c_o=1`. The carry propagates through all 16 stages.
- Maximum operands: `a_i=16'hffff`, `b_i=16'hffff` -> `s_o=16'hfffe`, `c_o=1`.
- Latency and back-to-back:
  - Change operands every cycle (0x0010+0x1011, then 0xffff+0x0001, then 0x0000+0x0000).
  - Outputs track one cycle behind: 0x1021/0, then 0x0000/1, then 0x0000/0.
  - Mid-cycle operand changes do not alter outputs.
- Async reset mid-stream: assert `rst_ni=0` between edges while `s_o=16'h1021` -> outputs clear to 0 before the next edge. Repeat the 0xffff+0xffff case with `LENGTH=1` -> `s_o=0`, `c_o=1`.
